seg_share_arbiter: RTL and testbench
====================================

SEG_SHARE_ARBITER -- requirements
Module: seg_share_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1000: number of cycles a granted value is displayed; legal range 1..65535.
REQ-002 SHALL have parameter GAP_CYCLES, default 16: number of blank cycles after each display; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ena, input, 1: when low, the block freezes; all state, counters and outputs hold.
REQ-006 SHALL have port req_a, input, 1: requester A wants the display; held high until ack_a.
REQ-007 SHALL have port data_a, input, 4: hex digit from requester A.
REQ-008 SHALL have port req_b, input, 1: requester B wants the display; held high until ack_b.
REQ-009 SHALL have port data_b, input, 4: hex digit from requester B.
REQ-010 SHALL have port ack_a, output, 1: one-cycle pulse when A's display slot completes.
REQ-011 SHALL have port ack_b, output, 1: one-cycle pulse when B's display slot completes.
REQ-012 SHALL have port segments, output, 7: active-high segments, bit0=a through bit6=g.
REQ-013 SHALL have port dp, output, 1: decimal point; 0 while showing A, 1 while showing B, 0 otherwise.
REQ-014 SHALL have port busy, output, 1: high in SHOW and GAP states.

Function
REQ-015 SHALL implement states IDLE, SHOW, GAP; all outputs registered.
REQ-016 IDLE: if any req is high with ena high, SHALL grant, capture the granted data nibble, load the hold counter and enter SHOW on the next edge.
REQ-017 Arbitration SHALL be round-robin: with both reqs high, grant the requester not granted last; with one req high, grant it regardless of pointer.
REQ-018 The last-grant pointer SHALL update on each grant; after reset it indicates B, so A wins the first tie.
REQ-019 SHOW SHALL last exactly HOLD_CYCLES enabled cycles; segments show the decoded captured nibble for all of them.
REQ-020 Hex decode SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71 (hex, bit6..bit0).
REQ-021 Captured data SHALL NOT change during SHOW; data inputs are sampled only at grant.
REQ-022 On leaving SHOW, SHALL enter GAP; the granted requester's ack SHALL be high for exactly the first GAP cycle.
REQ-023 GAP SHALL last exactly GAP_CYCLES enabled cycles with segments=0 and dp=0, then return to IDLE.
REQ-024 A req deasserted mid-SHOW SHALL NOT shorten the slot; the ack SHALL still pulse.
REQ-025 A requester whose req is still high in IDLE after its ack SHALL be treated as a new request.
REQ-026 In IDLE, segments=0, dp=0, busy=0.
REQ-027 When ena is low, counters SHALL NOT decrement, no grant SHALL occur, and an ack due that cycle SHALL be deferred until the first enabled cycle.
REQ-028 ack_a and ack_b SHALL never be high simultaneously.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counters 0, pointer=B, segments=0, dp=0, busy=0, ack_a=0, ack_b=0, regardless of clk.
REQ-030 Reset asserted mid-SHOW or mid-GAP SHALL abort the slot with no ack; after release, operation resumes from IDLE.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2)
REQ-031 req_a=1, data_a=5 -> next edge: SHOW, segments=6D, dp=0 for 4 cycles; then ack_a for 1 cycle, segments=00 for 2 cycles, then IDLE.
REQ-032 req_a=req_b=1 from reset, data_a=1, data_b=A -> A shown (06, dp=0), then B shown (77, dp=1), alternating while both stay high.
REQ-033 ena pulled low for 3 cycles during SHOW -> segments held; SHOW totals 4 enabled cycles; ack timing shifted by 3.
REQ-034 data_a changed from 3 to 8 during SHOW -> segments remain 4F for the whole slot.
REQ-035 rst_n low at SHOW cycle 2 -> outputs 0 asynchronously, no ack; after release, req_a still high re-grants A.
REQ-036 Sweep all 16 nibbles on data_b -> segments match the REQ-020 table.

Source files
------------

// File: rtl/seg_share_arbiter.sv
// Two requesters share one seven-segment digit: round-robin grant, fixed hold time,
// blank gap with a one-cycle ack to the owner of the slot that just ended.
module seg_share_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       req_a,
    input  logic [3:0] data_a,
    input  logic       req_b,
    input  logic [3:0] data_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic [6:0] segments,
    output logic       dp,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StGap
    } state_t;

    localparam logic [15:0] HoldLoad = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GapLoad  = 16'(GAP_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        last_b;
    logic        owner_b;
    logic        grant_b;
    logic [3:0]  sel_data;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // B wins only when A is absent or A was granted last (tie goes to A after reset).
    assign grant_b  = req_b && (!req_a || !last_b);
    assign sel_data = grant_b ? data_b : data_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            cnt      <= '0;
            last_b   <= 1'b1;
            owner_b  <= 1'b0;
            segments <= '0;
            dp       <= 1'b0;
            busy     <= 1'b0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
        end else if (ena) begin
            unique case (state)
                StIdle: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    if (req_a || req_b) begin
                        state    <= StShow;
                        owner_b  <= grant_b;
                        last_b   <= grant_b;
                        segments <= hex7(sel_data);
                        dp       <= grant_b;
                        busy     <= 1'b1;
                        cnt      <= HoldLoad;
                    end
                end
                StShow: begin
                    if (cnt == '0) begin
                        state    <= StGap;
                        cnt      <= GapLoad;
                        segments <= '0;
                        dp       <= 1'b0;
                        ack_a    <= !owner_b;
                        ack_b    <= owner_b;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                StGap: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    if (cnt == '0) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state    <= StIdle;
                    busy     <= 1'b0;
                    segments <= '0;
                    dp       <= 1'b0;
                    ack_a    <= 1'b0;
                    ack_b    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Directed bench for seg_share_arbiter with HOLD_CYCLES=4, GAP_CYCLES=2.
module tb_seg_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       req_a;
    logic [3:0] data_a;
    logic       req_b;
    logic [3:0] data_b;
    logic       ack_a;
    logic       ack_b;
    logic [6:0] segments;
    logic       dp;
    logic       busy;

    int total = 0;
    int bad   = 0;

    seg_share_arbiter #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req_a   (req_a),
        .data_a  (data_a),
        .req_b   (req_b),
        .data_b  (data_b),
        .ack_a   (ack_a),
        .ack_b   (ack_b),
        .segments(segments),
        .dp      (dp),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_blank(input string name);
        check({name, "_seg"}, 32'(segments), 32'h0);
        check({name, "_dp"}, 32'(dp), 32'h0);
    endtask

    // Grant edge, 4 SHOW cycles, ack + 2 GAP cycles, back to IDLE.
    task automatic run_slot(input bit is_b, input logic [6:0] exp_seg, input bit rel);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("show_seg", 32'(segments), 32'(exp_seg));
            check("show_dp", 32'(dp), 32'(is_b));
            check("show_busy", 32'(busy), 32'h1);
            check("show_noack", 32'({ack_a, ack_b}), 32'h0);
        end
        tick();
        check("gap1_ack_a", 32'(ack_a), 32'(!is_b));
        check("gap1_ack_b", 32'(ack_b), 32'(is_b));
        check("gap1_busy", 32'(busy), 32'h1);
        check_blank("gap1");
        if (rel) begin
            if (is_b) req_b = 1'b0;
            else req_a = 1'b0;
        end
        tick();
        check("gap2_ack", 32'({ack_a, ack_b}), 32'h0);
        check("gap2_busy", 32'(busy), 32'h1);
        check_blank("gap2");
        tick();
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_ack", 32'({ack_a, ack_b}), 32'h0);
        check_blank("idle");
    endtask

    initial begin
        vecs[0]  = '{4'h0, 7'h3F};
        vecs[1]  = '{4'h1, 7'h06};
        vecs[2]  = '{4'h2, 7'h5B};
        vecs[3]  = '{4'h3, 7'h4F};
        vecs[4]  = '{4'h4, 7'h66};
        vecs[5]  = '{4'h5, 7'h6D};
        vecs[6]  = '{4'h6, 7'h7D};
        vecs[7]  = '{4'h7, 7'h07};
        vecs[8]  = '{4'h8, 7'h7F};
        vecs[9]  = '{4'h9, 7'h6F};
        vecs[10] = '{4'hA, 7'h77};
        vecs[11] = '{4'hB, 7'h7C};
        vecs[12] = '{4'hC, 7'h39};
        vecs[13] = '{4'hD, 7'h5E};
        vecs[14] = '{4'hE, 7'h79};
        vecs[15] = '{4'hF, 7'h71};

        rst_n  = 1'b0;
        ena    = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 4'h0;
        data_b = 4'h0;
        tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ack", 32'({ack_a, ack_b}), 32'h0);
        check_blank("rst");
        rst_n = 1'b1;
        tick();

        // Single A request, digit 5.
        req_a  = 1'b1;
        data_a = 4'h5;
        run_slot(1'b0, 7'h6D, 1'b1);

        // Both requesting from reset: A first, then alternate.
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        req_a  = 1'b1;
        data_a = 4'h1;
        req_b  = 1'b1;
        data_b = 4'hA;
        run_slot(1'b0, 7'h06, 1'b0);
        run_slot(1'b1, 7'h77, 1'b0);
        run_slot(1'b0, 7'h06, 1'b0);
        run_slot(1'b1, 7'h77, 1'b1);
        // A still held after its ack is a fresh request; lone requester wins regardless of pointer.
        run_slot(1'b0, 7'h06, 1'b0);
        run_slot(1'b0, 7'h06, 1'b1);

        // ena low in IDLE: no grant.
        ena   = 1'b0;
        req_a = 1'b1;
        data_a = 4'h2;
        tick();
        tick();
        check("frz_idle_busy", 32'(busy), 32'h0);
        check("frz_idle_seg", 32'(segments), 32'h0);
        ena = 1'b1;

        // ena low for 3 cycles mid-SHOW shifts the ack by 3.
        tick();
        check("ena_show1", 32'(segments), 32'h5B);
        tick();
        check("ena_show2", 32'(segments), 32'h5B);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ena_frz_seg", 32'(segments), 32'h5B);
            check("ena_frz_busy", 32'(busy), 32'h1);
            check("ena_frz_ack", 32'(ack_a), 32'h0);
        end
        ena = 1'b1;
        tick();
        check("ena_show3", 32'(segments), 32'h5B);
        check("ena_show3_ack", 32'(ack_a), 32'h0);
        tick();
        check("ena_show4", 32'(segments), 32'h5B);
        check("ena_show4_ack", 32'(ack_a), 32'h0);
        tick();
        check("ena_ack", 32'(ack_a), 32'h1);
        check_blank("ena_gap");
        req_a = 1'b0;
        tick();
        tick();
        check("ena_idle", 32'(busy), 32'h0);

        // Data change during SHOW is ignored; req dropped mid-SHOW still gets its ack.
        req_a  = 1'b1;
        data_a = 4'h3;
        tick();
        data_a = 4'h8;
        req_a  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("cap_seg", 32'(segments), 32'h4F);
            tick();
        end
        check("cap_ack", 32'(ack_a), 32'h1);
        tick();
        tick();
        check("cap_idle", 32'(busy), 32'h0);

        // Reset at SHOW cycle 2 aborts without ack, then A re-granted.
        req_a  = 1'b1;
        data_a = 4'h5;
        tick();
        tick();
        check("pre_rst_seg", 32'(segments), 32'h6D);
        rst_n = 1'b0;
        #1;
        check("arst_seg", 32'(segments), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_dp", 32'(dp), 32'h0);
        tick();
        check("rst_hold_ack", 32'({ack_a, ack_b}), 32'h0);
        rst_n = 1'b1;
        run_slot(1'b0, 7'h6D, 1'b1);

        // Decode sweep on B.
        for (int i = 0; i < 16; i++) begin
            data_b = vecs[i].nib;
            req_b  = 1'b1;
            run_slot(1'b1, vecs[i].seg, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    always @(negedge clk) begin
        if (ack_a && ack_b) begin
            bad++;
            $display("FAIL both_acks: ack_a=%0b ack_b=%0b expected not both", ack_a, ack_b);
        end
    end

endmodule
